// File: rtl/scalar_mul_ctrl.sv
// Right-to-left double-and-add-always sequencer driving external point-add/double units.
// Optional SCALAR_MUL_EARLY_EXIT_EN: stop once the remaining scalar bits are all zero.
module scalar_mul_ctrl #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_pa_start,
  output logic             o_pa_add,
  output logic [WIDTH-1:0] o_pa_x1,
  output logic [WIDTH-1:0] o_pa_y1,
  output logic [WIDTH-1:0] o_pa_x2,
  output logic [WIDTH-1:0] o_pa_y2,
  input  logic             i_pa_finish,
  input  logic [WIDTH-1:0] i_pa_x,
  input  logic [WIDTH-1:0] i_pa_y,
  output logic             o_pd_start,
  output logic [WIDTH-1:0] o_pd_x,
  output logic [WIDTH-1:0] o_pd_y,
  input  logic             i_pd_finish,
  input  logic [WIDTH-1:0] i_pd_x,
  input  logic [WIDTH-1:0] i_pd_y,
  output logic             o_busy,
  output logic             o_finished,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StUpdate, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] qx_q, qx_d, qy_q, qy_d;
  logic [WIDTH-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [WIDTH-1:0] pax_q, pax_d, pay_q, pay_d;
  logic [WIDTH-1:0] pdx_q, pdx_d, pdy_q, pdy_d;
  logic [WIDTH-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pa_done_q, pa_done_d, pd_done_q, pd_done_d;
  logic             last_iter;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    pax_d     = pax_q;
    pay_d     = pay_q;
    pdx_d     = pdx_q;
    pdy_d     = pdy_q;
    res_x_d   = res_x_q;
    res_y_d   = res_y_q;
    cnt_d     = cnt_q;
    pa_done_d = pa_done_q;
    pd_done_d = pd_done_q;
`ifdef SCALAR_MUL_EARLY_EXIT_EN
    last_iter = (cnt_q == CntW'(WIDTH - 1)) || ((k_q >> 1) == '0);
`else
    last_iter = (cnt_q == CntW'(WIDTH - 1));
`endif

    case (state_q)
      StIdle: begin
        if (i_start) begin
          k_d     = i_k;
          tx_d    = i_x;
          ty_d    = i_y;
          // All-ones encodes the point at infinity.
          qx_d    = '1;
          qy_d    = '1;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // First finish of each unit wins; repeats are dropped.
        if (i_pa_finish && !pa_done_q) begin
          pa_done_d = 1'b1;
          pax_d     = i_pa_x;
          pay_d     = i_pa_y;
        end
        if (i_pd_finish && !pd_done_q) begin
          pd_done_d = 1'b1;
          pdx_d     = i_pd_x;
          pdy_d     = i_pd_y;
        end
        if (pa_done_q && pd_done_q) state_d = StUpdate;
      end
      StUpdate: begin
        qx_d      = pax_q;
        qy_d      = pay_q;
        tx_d      = pdx_q;
        ty_d      = pdy_q;
        k_d       = k_q >> 1;
        cnt_d     = cnt_q + 1'b1;
        pa_done_d = 1'b0;
        pd_done_d = 1'b0;
        if (last_iter) begin
          res_x_d = pax_q;
          res_y_d = pay_q;
          state_d = StDone;
        end else begin
          state_d = StIssue;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      pax_q     <= '0;
      pay_q     <= '0;
      pdx_q     <= '0;
      pdy_q     <= '0;
      res_x_q   <= '0;
      res_y_q   <= '0;
      cnt_q     <= '0;
      pa_done_q <= 1'b0;
      pd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      pax_q     <= pax_d;
      pay_q     <= pay_d;
      pdx_q     <= pdx_d;
      pdy_q     <= pdy_d;
      res_x_q   <= res_x_d;
      res_y_q   <= res_y_d;
      cnt_q     <= cnt_d;
      pa_done_q <= pa_done_d;
      pd_done_q <= pd_done_d;
    end
  end

  assign o_pa_start = (state_q == StIssue);
  assign o_pd_start = (state_q == StIssue);
  assign o_pa_add   = k_q[0];
  assign o_pa_x1    = qx_q;
  assign o_pa_y1    = qy_q;
  assign o_pa_x2    = tx_q;
  assign o_pa_y2    = ty_q;
  assign o_pd_x     = tx_q;
  assign o_pd_y     = ty_q;
  assign o_busy     = (state_q != StIdle);
  assign o_finished = (state_q == StDone);
  assign o_result_x = res_x_q;
  assign o_result_y = res_y_q;

endmodule

// File: tb/tb_scalar_mul_ctrl.sv
// Scoreboard bench for scalar_mul_ctrl, WIDTH=8, curve y^2 = x^3 + 2x + 2 mod 17, P = (5,1).
module tb_scalar_mul_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_k = '0, i_x = '0, i_y = '0;
  logic       o_pa_start, o_pa_add, o_pd_start, o_busy, o_finished;
  logic [7:0] o_pa_x1, o_pa_y1, o_pa_x2, o_pa_y2, o_pd_x, o_pd_y, o_result_x, o_result_y;
  logic       pa_fin = 1'b0, pd_fin = 1'b0;
  logic [7:0] pa_rx = '0, pa_ry = '0, pd_rx = '0, pd_ry = '0;

  scalar_mul_ctrl #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_k(i_k), .i_x(i_x), .i_y(i_y),
    .o_pa_start(o_pa_start), .o_pa_add(o_pa_add),
    .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1), .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2),
    .i_pa_finish(pa_fin), .i_pa_x(pa_rx), .i_pa_y(pa_ry),
    .o_pd_start(o_pd_start), .o_pd_x(o_pd_x), .o_pd_y(o_pd_y),
    .i_pd_finish(pd_fin), .i_pd_x(pd_rx), .i_pd_y(pd_ry),
    .o_busy(o_busy), .o_finished(o_finished), .o_result_x(o_result_x), .o_result_y(o_result_y)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, fin_count = 0;
  int n_pa = 0, n_pd = 0, n_add = 0;
  int pa_fix = 0, pd_fix = 0;  // 0 selects random 3..7 latency
  bit pa_dup = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Curve arithmetic mod 17, a = 2; all-ones is infinity.
  function automatic int md(input int a);
    return ((a % 17) + 17) % 17;
  endfunction

  function automatic int inv(input int a);
    int r = 1;
    for (int i = 0; i < 15; i++) r = md(r * md(a));
    return r;
  endfunction

  function automatic logic [15:0] pdbl(input logic [7:0] x, input logic [7:0] y);
    int xi, yi, l, x3, y3;
    if ({x, y} == 16'hFFFF || y == 8'd0) return 16'hFFFF;
    xi = int'(x);
    yi = int'(y);
    l  = md((3 * xi * xi + 2) * inv(2 * yi));
    x3 = md(l * l - 2 * xi);
    y3 = md(l * (xi - x3) - yi);
    return {x3[7:0], y3[7:0]};
  endfunction

  function automatic logic [15:0] padd(input logic [7:0] x1, input logic [7:0] y1,
                                       input logic [7:0] x2, input logic [7:0] y2);
    int a, b, c, d, l, x3, y3;
    if ({x1, y1} == 16'hFFFF) return {x2, y2};
    if ({x2, y2} == 16'hFFFF) return {x1, y1};
    a = int'(x1); b = int'(y1); c = int'(x2); d = int'(y2);
    if (a == c) begin
      if (md(b + d) == 0) return 16'hFFFF;
      return pdbl(x1, y1);
    end
    l  = md((d - b) * inv(c - a));
    x3 = md(l * l - a - c);
    y3 = md(l * (a - x3) - b);
    return {x3[7:0], y3[7:0]};
  endfunction

  function automatic int iters(input logic [7:0] k);
`ifdef SCALAR_MUL_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 8; i++) if (k[i]) n = i + 1;
    return n;
`else
    return 8;
`endif
  endfunction

  // Point-add unit model; not reset, so late finishes after i_rst reach the DUT.
  int pa_cnt = 0, pd_cnt = 0;
  bit dup_pend = 1'b0;
  logic [15:0] pa_res = '0, pd_res = '0;
  always @(posedge clk) begin
    pa_fin   <= 1'b0;
    dup_pend <= 1'b0;
    if (o_pa_start) begin
      pa_res <= o_pa_add ? padd(o_pa_x1, o_pa_y1, o_pa_x2, o_pa_y2) : {o_pa_x1, o_pa_y1};
      pa_cnt <= (pa_fix != 0) ? pa_fix : int'($urandom_range(7, 3));
    end else if (pa_cnt != 0) begin
      pa_cnt <= pa_cnt - 1;
      if (pa_cnt == 1) begin
        pa_fin   <= 1'b1;
        {pa_rx, pa_ry} <= pa_res;
        dup_pend <= pa_dup;
      end
    end else if (dup_pend) begin
      pa_fin <= 1'b1;
      pa_rx  <= 8'h00;
      pa_ry  <= 8'h00;
    end
  end

  always @(posedge clk) begin
    pd_fin <= 1'b0;
    if (o_pd_start) begin
      pd_res <= pdbl(o_pd_x, o_pd_y);
      pd_cnt <= (pd_fix != 0) ? pd_fix : int'($urandom_range(7, 3));
    end else if (pd_cnt != 0) begin
      pd_cnt <= pd_cnt - 1;
      if (pd_cnt == 1) begin
        pd_fin <= 1'b1;
        {pd_rx, pd_ry} <= pd_res;
      end
    end
  end

  always @(posedge clk) begin
    if (o_pa_start) n_pa <= n_pa + 1;
    if (o_pd_start) n_pd <= n_pd + 1;
    if (o_pa_start && o_pa_add) n_add <= n_add + 1;
  end

  // Monitor: pops an expected result on every o_finished pulse.
  initial forever begin
    logic [15:0] e;
    @(negedge clk);
    if (o_finished === 1'b1) begin
      fin_count++;
      check("finish_expected", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result_x", o_result_x, e[15:8]);
        check("result_y", o_result_y, e[7:0]);
      end
    end
  end

  task automatic wait_fin(input int f0);
    for (int c = 0; c < 3000 && fin_count == f0; c++) @(negedge clk);
    @(negedge clk);
    check("finish_count", fin_count - f0, 1);
  endtask

  task automatic run(input logic [7:0] k, input logic [7:0] ex, input logic [7:0] ey,
                     input bit hold);
    int pa0, pd0, ad0, f0;
    pa0 = n_pa; pd0 = n_pd; ad0 = n_add; f0 = fin_count;
    @(negedge clk);
    i_k = k; i_x = 8'd5; i_y = 8'd1; i_start = 1'b1;
    exp_q.push_back({ex, ey});
    @(negedge clk);
    if (hold) begin
      i_k = 8'hA5;  // must not be picked up while busy
      for (int c = 0; c < 3000 && fin_count == f0; c++) @(negedge clk);
    end
    i_start = 1'b0;
    wait_fin(f0);
    check("pa_start_count", n_pa - pa0, iters(k));
    check("pd_start_count", n_pd - pd0, iters(k));
    check("add_flag_count", n_add - ad0, $countones(k));
  endtask

  initial begin
    int pa0;
    #12;
    check("rst_busy", o_busy, 0);
    check("rst_finished", o_finished, 0);
    check("rst_pa_start", o_pa_start, 0);
    check("rst_result_x", o_result_x, 0);
    check("rst_result_y", o_result_y, 0);
    @(negedge clk);
    rst = 1'b0;

    run(8'd1, 8'd5,  8'd1,  1'b0);
    run(8'd5, 8'd9,  8'd16, 1'b0);
    run(8'd2, 8'd6,  8'd3,  1'b0);
    run(8'd4, 8'd3,  8'd1,  1'b0);
    run(8'd0, 8'hFF, 8'hFF, 1'b0);

    // Finish ordering with k=3: double first, add first (plus duplicate add finish), same cycle.
    pa_fix = 7; pd_fix = 3;
    run(8'd3, 8'd10, 8'd6, 1'b0);
    pa_fix = 3; pd_fix = 7; pa_dup = 1'b1;
    run(8'd3, 8'd10, 8'd6, 1'b0);
    pa_fix = 5; pd_fix = 5; pa_dup = 1'b0;
    run(8'd3, 8'd10, 8'd6, 1'b0);
    pa_fix = 0; pd_fix = 0;

    // Reset during iteration 3 of k=5.
    pa0 = n_pa;
    @(negedge clk);
    i_k = 8'd5; i_x = 8'd5; i_y = 8'd1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 500 && (n_pa - pa0) < 3; c++) @(negedge clk);
    check("iter3_reached", n_pa - pa0, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_pa_start", o_pa_start, 0);
    check("mid_rst_pd_start", o_pd_start, 0);
    check("mid_rst_finished", o_finished, 0);
    check("mid_rst_pa_x1", o_pa_x1, 0);
    check("mid_rst_pd_x", o_pd_x, 0);
    check("mid_rst_result_x", o_result_x, 0);
    check("mid_rst_result_y", o_result_y, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle", o_busy, 0);
    run(8'd2, 8'd6, 8'd3, 1'b0);

    // i_start held high for the whole run.
    run(8'd4, 8'd3, 8'd1, 1'b1);
    pa0 = fin_count;
    repeat (50) @(negedge clk);
    check("no_extra_finish", fin_count - pa0, 0);
    check("idle_after_hold", o_busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_mul_ctrl.md
Name: scalar_mul_ctrl

Overview:
- Initiator-side sequencer for elliptic-curve scalar multiplication Q = k·P using right-to-left double-and-add-always.
- Each scalar bit drives one point-add request with the add flag set to that bit, and one point-double request. Both requests are always issued, so execution is constant-time.
- Drives the start/finish handshake of an external point-add unit and an external point-double unit, and collects their results.
- Sits above the point arithmetic units in the ECC top level.

Parameters:
WIDTH, 256, bit width of coordinates and of the scalar.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  one-cycle request to begin; sampled only in IDLE
i_k  in  WIDTH  scalar k; latched on accepted start
i_x  in  WIDTH  base point P x-coordinate; latched on start
i_y  in  WIDTH  base point P y-coordinate; latched on start
o_pa_start  out  1  one-cycle start pulse to the point-add unit
o_pa_add  out  1  add flag to the point-add unit (current scalar bit)
o_pa_x1  out  WIDTH  accumulator Q x-coordinate
o_pa_y1  out  WIDTH  accumulator Q y-coordinate
o_pa_x2  out  WIDTH  running point T x-coordinate
o_pa_y2  out  WIDTH  running point T y-coordinate
i_pa_finish  in  1  point-add done pulse
i_pa_x  in  WIDTH  point-add result x
i_pa_y  in  WIDTH  point-add result y
o_pd_start  out  1  one-cycle start pulse to the point-double unit
o_pd_x  out  WIDTH  T x-coordinate to be doubled
o_pd_y  out  WIDTH  T y-coordinate to be doubled
i_pd_finish  in  1  point-double done pulse
i_pd_x  in  WIDTH  point-double result x
i_pd_y  in  WIDTH  point-double result y
o_busy  out  1  high whenever the FSM is not in IDLE
o_finished  out  1  one-cycle pulse; results are valid from this cycle on
o_result_x  out  WIDTH  x-coordinate of k·P
o_result_y  out  WIDTH  y-coordinate of k·P

Behaviour:
- Point at infinity is encoded as x = y = all-ones.
- Reset (asynchronous, i_rst=1), which also applies mid-operation:
  - state = IDLE.
  - All outputs 0, except o_result_x and o_result_y, which are 0.
  - Q, T, scalar and counter registers cleared; sticky finish flags cleared.
  - Any in-flight unit operation is abandoned. Finish pulses arriving after reset are ignored, because only WAIT samples them.
- IDLE:
  - On i_start: latch k, set T = (i_x, i_y), set Q = infinity, cnt = 0, go to ISSUE.
  - i_start in any other state is ignored.
- ISSUE, one cycle:
  - Assert o_pa_start and o_pd_start together.
  - o_pa_add = k_r[0].
  - pa/pd data ports are driven from the Q and T registers and stay stable until UPDATE.
  - Go to WAIT.
- WAIT:
  - Set sticky flag pa_done on i_pa_finish and capture (i_pa_x, i_pa_y).
  - Set sticky flag pd_done on i_pd_finish and capture (i_pd_x, i_pd_y).
  - Finishes may arrive in either order, or in the same cycle.
  - When both flags are set, go to UPDATE.
  - A duplicate finish while its flag is already set is ignored; the first capture is kept.
- UPDATE, one cycle:
  - Q = captured add result. The add unit itself returns Q unchanged when add=0.
  - T = captured double result.
  - k_r >>= 1; cnt++; clear both flags.
  - If cnt was WIDTH-1, go to DONE; otherwise go to ISSUE.
- DONE, one cycle:
  - o_result = Q; o_finished = 1; go to IDLE.
  - o_result holds its value until the next accepted start completes.
- Latency: exactly WIDTH iterations. Each iteration is 3 cycles plus the slower unit's latency. Total = 2 + WIDTH·(2 + max unit latency + 1) when that latency is constant.
- The unit contract guarantees finish comes ≥ 2 cycles after start. Finishes during ISSUE are not sampled.
- k = 0: every add has add=0, so Q stays infinity and the result is all-ones.
- The doubling in the final iteration is issued anyway to keep timing constant.

Optional Feature:
- Macro: SCALAR_MUL_EARLY_EXIT_EN.
- Defined:
  - In UPDATE, if the shifted k_r == 0, go directly to DONE.
  - Latency then depends on k: k=0 yields 1 iteration (the add runs with add=0). Timing is not constant-time.
- Undefined: always WIDTH iterations.

Test Plan:
Bench setup: WIDTH=8; behavioural add/double models for y²=x³+2x+2 mod 17 with P=(5,1) and 3–7 cycle random latency.
- k=1 -> o_finished after 8 iterations, result (5,1); exactly 8 o_pa_start and 8 o_pd_start pulses.
- k=5 -> result (9,16); k=2 -> (6,3); k=4 -> (3,1).
- k=0 -> result (0xFF,0xFF); o_pa_add low on all 8 requests.
- Double unit finishes 4 cycles before add unit, then after it, then in the same cycle, with k=3 -> result (10,6) in every case; a duplicate i_pa_finish pulse has no effect.
- i_rst pulsed during iteration 3 of k=5 -> all outputs 0 immediately, o_busy=0; a new start with k=2 returns (6,3).
- i_start held high during a run -> ignored; exactly one o_finished per accepted start. With SCALAR_MUL_EARLY_EXIT_EN and k=1 -> 1 iteration, result (5,1).
